// File: rtl/ising_config.sv
// Shared constants for the GPIO configuration bus: bus field positions, readback
// addresses, decode classes and the bytes-per-register helper.
package ising_config;

  localparam logic [15:0] RB_SEL_ADDR  = 16'hFFF0;
  localparam logic [15:0] RB_NEXT_ADDR = 16'hFFF1;

  typedef enum logic [2:0] {
    DEC_TRIG,
    DEC_DATA,
    DEC_RB_SEL,
    DEC_RB_NEXT,
    DEC_BAD
  } dec_cls_e;

  // Write-clock bit sits above the data byte, which sits above the address.
  function automatic int wclk_pos(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int data_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int bpr(input int reg_width, input int data_w);
    return reg_width / data_w;
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Synchronises the asynchronous GPIO write bus and turns each rising edge of the
// write-clock bit into a one-cycle registered event carrying address and data.
module gpio_sync_edge #(
  parameter int GPIO_ADDR_W = 16,
  parameter int GPIO_DATA_W = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [GPIO_ADDR_W+GPIO_DATA_W:0]   i_gpio,
  output logic                               o_evt,
  output logic [GPIO_ADDR_W-1:0]             o_addr,
  output logic [GPIO_DATA_W-1:0]             o_data
);
  import ising_config::*;

  localparam int BW   = GPIO_ADDR_W + GPIO_DATA_W + 1;
  localparam int WCLK = wclk_pos(GPIO_ADDR_W, GPIO_DATA_W);
  localparam int DLSB = data_lsb(GPIO_ADDR_W);

  logic [SYNC_STAGES-1:0][BW-1:0] r_sync;
  logic [BW-1:0]                  w_sync_q;
  logic                           w_rise;
  logic                           r_wclk_d;
  logic                           r_evt;
  logic [GPIO_ADDR_W-1:0]         r_addr;
  logic [GPIO_DATA_W-1:0]         r_data;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_sync_q[WCLK] & ~r_wclk_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync   <= '0;
      r_wclk_d <= 1'b0;
      r_evt    <= 1'b0;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_sync[0] <= i_gpio;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_wclk_d <= w_sync_q[WCLK];
      r_evt    <= w_rise;
      if (w_rise) begin
        r_addr <= w_sync_q[GPIO_ADDR_W-1:0];
        r_data <= w_sync_q[DLSB +: GPIO_DATA_W];
      end
    end
  end

  assign o_evt  = r_evt;
  assign o_addr = r_addr;
  assign o_data = r_data;

endmodule

// File: rtl/gpio_cfg_bus_v2.sv
// GPIO write-bus decoder: assembles byte-serial writes into config registers,
// fires trigger pulses, and serves snapshot-coherent multi-byte readback.
module gpio_cfg_bus_v2 #(
  parameter int GPIO_ADDR_W = 16,
  parameter int GPIO_DATA_W = 8,
  parameter int REG_WIDTH   = 32,
  parameter int NUM_REGS    = 64,
  parameter int NUM_TRIG    = 4,
  parameter int NUM_RB      = 16,
  parameter int SYNC_STAGES = 2,
  parameter logic [GPIO_ADDR_W-1:0] RB_SEL_ADDR  = ising_config::RB_SEL_ADDR,
  parameter logic [GPIO_ADDR_W-1:0] RB_NEXT_ADDR = ising_config::RB_NEXT_ADDR
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [GPIO_ADDR_W+GPIO_DATA_W:0] gpio_in,
  output logic [NUM_REGS*REG_WIDTH-1:0]    regs_out,
  output logic [NUM_REGS-1:0]              reg_wr_stb,
  output logic [NUM_TRIG-1:0]              trig_out,
  input  logic [NUM_RB*REG_WIDTH-1:0]      rb_in,
  output logic [GPIO_DATA_W-1:0]           gpio_out,
  output logic [7:0]                       bad_addr_cnt
);
  import ising_config::*;

  localparam int BPR = bpr(REG_WIDTH, GPIO_DATA_W);
  localparam int CW  = (BPR > 1) ? $clog2(BPR) : 1;

  logic                               w_evt;
  logic [GPIO_ADDR_W-1:0]             w_addr;
  logic [GPIO_DATA_W-1:0]             w_data;
  dec_cls_e                           w_cls;
  logic [CW-1:0]                      w_cnt_cur;
  logic [CW-1:0]                      w_ptr_nxt;
  logic [BPR-1:0][GPIO_DATA_W-1:0]    w_stage_nxt;
  logic [BPR-1:0][GPIO_DATA_W-1:0]    w_rb_sel;

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]                r_wr_stb;
  logic [NUM_TRIG-1:0]                r_trig;
  logic [BPR-1:0][GPIO_DATA_W-1:0]    r_stage;
  logic [CW-1:0]                      r_byte_cnt;
  logic [GPIO_ADDR_W-1:0]             r_last_addr;
  logic [BPR-1:0][GPIO_DATA_W-1:0]    r_shadow;
  logic [CW-1:0]                      r_rb_ptr;
  logic [GPIO_DATA_W-1:0]             r_gpio_out;
  logic [7:0]                         r_bad_cnt;

  gpio_sync_edge #(
    .GPIO_ADDR_W (GPIO_ADDR_W),
    .GPIO_DATA_W (GPIO_DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_gpio (gpio_in),
    .o_evt  (w_evt),
    .o_addr (w_addr),
    .o_data (w_data)
  );

  always_comb begin
    w_cls = DEC_BAD;
    if (w_addr == RB_SEL_ADDR)                    w_cls = DEC_RB_SEL;
    else if (w_addr == RB_NEXT_ADDR)              w_cls = DEC_RB_NEXT;
    else if (w_addr < GPIO_ADDR_W'(NUM_TRIG))     w_cls = DEC_TRIG;
    else if (w_addr < GPIO_ADDR_W'(NUM_REGS))     w_cls = DEC_DATA;
  end

  // A change of address abandons any partially assembled word.
  assign w_cnt_cur = (w_addr == r_last_addr) ? r_byte_cnt : '0;
  assign w_ptr_nxt = (r_rb_ptr == CW'(BPR-1)) ? '0 : r_rb_ptr + CW'(1);

  always_comb begin
    w_stage_nxt            = r_stage;
    w_stage_nxt[w_cnt_cur] = w_data;
  end

  always_comb begin
    w_rb_sel = '0;
    for (int i = 0; i < NUM_RB; i++)
      if (w_data == GPIO_DATA_W'(i)) w_rb_sel = rb_in[i*REG_WIDTH +: REG_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_regs      <= '0;
      r_wr_stb    <= '0;
      r_trig      <= '0;
      r_stage     <= '0;
      r_byte_cnt  <= '0;
      r_last_addr <= '1;
      r_shadow    <= '0;
      r_rb_ptr    <= '0;
      r_gpio_out  <= '0;
      r_bad_cnt   <= '0;
    end else begin
      r_wr_stb <= '0;
      r_trig   <= '0;
      if (w_evt) begin
        case (w_cls)
          DEC_TRIG: begin
            for (int i = 0; i < NUM_TRIG; i++) r_trig[i] <= (w_addr == GPIO_ADDR_W'(i));
            r_byte_cnt <= '0;
          end
          DEC_DATA: begin
            r_last_addr <= w_addr;
            r_stage     <= w_stage_nxt;
            if (w_cnt_cur == CW'(BPR-1)) begin
              r_byte_cnt <= '0;
              for (int i = NUM_TRIG; i < NUM_REGS; i++) begin
                if (w_addr == GPIO_ADDR_W'(i)) begin
                  r_regs[i]   <= w_stage_nxt;
                  r_wr_stb[i] <= 1'b1;
                end
              end
            end else begin
              r_byte_cnt <= w_cnt_cur + CW'(1);
            end
          end
          // gpio_out is loaded from the next-state shadow/pointer so it tracks the event without extra lag.
          DEC_RB_SEL: begin
            r_shadow   <= w_rb_sel;
            r_rb_ptr   <= '0;
            r_gpio_out <= w_rb_sel[0];
          end
          DEC_RB_NEXT: begin
            r_rb_ptr   <= w_ptr_nxt;
            r_gpio_out <= r_shadow[w_ptr_nxt];
          end
          DEC_BAD: begin
            if (r_bad_cnt != 8'hFF) r_bad_cnt <= r_bad_cnt + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign regs_out     = r_regs;
  assign reg_wr_stb   = r_wr_stb;
  assign trig_out     = r_trig;
  assign gpio_out     = r_gpio_out;
  assign bad_addr_cnt = r_bad_cnt;

endmodule
